// File: rtl/alu_seq_divider.sv
// Multi-cycle unsigned restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per clock, with a one-cycle done pulse and held results.
module alu_seq_divider #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_zero_flag,
    output logic           zero_flag
);

    localparam int CW = $clog2(2 * N);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    // The dividend shifts out of the top while quotient bits shift in at
    // the bottom, so after 2N iterations this register holds the quotient.
    logic [2*N-1:0] dvd_shift;
    logic [N-1:0]   dsr;
    logic [N-1:0]   rem;
    logic [CW-1:0]  cnt;

    logic [N:0]     trial;
    logic           fits;
    logic [N-1:0]   rem_next;
    logic [2*N-1:0] shift_next;
    logic           last_iter;

    // One restoring step: bring down the next dividend bit and try a subtract.
    always_comb begin
        trial      = {rem, dvd_shift[2*N-1]};
        fits       = trial >= {1'b0, dsr};
        // The restored value is always below the divisor, so N bits suffice.
        rem_next   = fits ? N'(trial - {1'b0, dsr}) : trial[N-1:0];
        shift_next = {dvd_shift[2*N-2:0], fits};
        last_iter  = (cnt == CW'(2 * N - 1));
    end

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = (divisor == '0) ? DONE : RUN;
            RUN:  if (last_iter) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and result registers; results load only on entry to DONE.
    // NOTE: every register, working and output alike, is cleared by reset so
    // an aborted operation leaves nothing behind and outputs read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_shift     <= '0;
            dsr           <= '0;
            rem           <= '0;
            cnt           <= '0;
            quotient      <= '0;
            remainder     <= '0;
            div_zero_flag <= 1'b0;
            zero_flag     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dvd_shift <= dividend;
                        dsr       <= divisor;
                        rem       <= '0;
                        cnt       <= '0;
                        if (divisor == '0) begin
                            quotient      <= '1;
                            remainder     <= dividend[N-1:0];
                            div_zero_flag <= 1'b1;
                            zero_flag     <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem       <= rem_next;
                    dvd_shift <= shift_next;
                    cnt       <= cnt + 1'b1;
                    if (last_iter) begin
                        quotient      <= shift_next;
                        remainder     <= rem_next;
                        div_zero_flag <= 1'b0;
                        zero_flag     <= (shift_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_alu_seq_divider.sv
// Directed self-checking bench for alu_seq_divider (N = 8).
module tb_alu_seq_divider;

    localparam int N = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           div_zero_flag;
    logic           zero_flag;

    int vectors     = 0;
    int miscompares = 0;

    alu_seq_divider #(.N(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .dividend      (dividend),
        .divisor       (divisor),
        .busy          (busy),
        .done          (done),
        .quotient      (quotient),
        .remainder     (remainder),
        .div_zero_flag (div_zero_flag),
        .zero_flag     (zero_flag)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check latency, results and the done pulse.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] exp_q, input logic [7:0] exp_r,
                          input logic exp_z, input logic exp_dz, input int exp_lat);
        int  n;
        bit  busy_bad;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);  // accept edge
        #1;
        start    = 1'b0;
        n        = 0;
        busy_bad = 1'b0;
        while (!done && n < 40) begin
            if (!busy) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 32'(n), 32'(exp_lat));
        check("busy_run", 32'(busy_bad), 32'd0);
        check("busy_done", 32'(busy), 32'd1);
        check("quotient", 32'(quotient), 32'(exp_q));
        check("remainder", 32'(remainder), 32'(exp_r));
        check("zero_flag", 32'(zero_flag), 32'(exp_z));
        check("div_zero_flag", 32'(div_zero_flag), 32'(exp_dz));
        @(posedge clk);
        #1;
        check("done_pulse", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("hold_quotient", 32'(quotient), 32'(exp_q));
    endtask

    initial begin
        int dones;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_flags", 32'({div_zero_flag, zero_flag}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 1'b0, 16);
        run_op(16'hFFFF, 8'hFF, 16'd257, 8'd0, 1'b0, 1'b0, 16);
        run_op(16'hFFFF, 8'd1, 16'hFFFF, 8'd0, 1'b0, 1'b0, 16);
        run_op(16'd0, 8'd5, 16'd0, 8'd0, 1'b1, 1'b0, 16);
        run_op(16'd4, 8'd9, 16'd0, 8'd4, 1'b1, 1'b0, 16);
        run_op(16'h1234, 8'd0, 16'hFFFF, 8'h34, 1'b0, 1'b1, 0);

        // Starts while busy (cycle 5 and the done cycle 16) must be ignored.
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'd1000;
        divisor  = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0;
        for (int k = 0; k <= 20; k++) begin
            if (k == 16) check("ign_done_cycle", 32'(done), 32'd1);
            if (k == 17) check("ign_not_requeued", 32'(busy), 32'd0);
            if (done) dones++;
            if (k == 5 || k == 16) begin
                start    = 1'b1;
                dividend = 16'd50;
                divisor  = 8'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("ign_done_count", 32'(dones), 32'd1);
        check("ign_quotient", 32'(quotient), 32'd142);
        check("ign_remainder", 32'(remainder), 32'd6);
        run_op(16'd50, 8'd5, 16'd10, 8'd0, 1'b0, 1'b0, 16);

        // Reset in the middle of an operation aborts it with no done.
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'd1000;
        divisor  = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_quotient", 32'(quotient), 32'd0);
        check("mid_remainder", 32'(remainder), 32'd0);
        check("mid_flags", 32'({div_zero_flag, zero_flag}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        check("mid_no_done", 32'(dones), 32'd0);
        run_op(16'd300, 8'd12, 16'd25, 8'd0, 1'b0, 1'b0, 16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
